// File: rtl/apb_pkg.sv
// apb_pkg: shared APB widths and requester FSM state encoding.
package apb_pkg;
   localparam int APB_ADDR_W = 3;
   localparam int APB_DATA_W = 32;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
endpackage

// File: rtl/apb_if.sv
// apb_if: APB bus between a single requester and the register-file completer.
interface apb_if import apb_pkg::*; #(
   parameter int ADDR_W = APB_ADDR_W,
   parameter int DATA_W = APB_DATA_W
);
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY);
   modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester turning valid/ready commands into
// SETUP/ACCESS cycles, with a one-cycle response strobe and optional ACCESS timeout.
module apb_master import apb_pkg::*; #(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   apb_if.master             apb
);
   localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT   = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   apb_state_e    state, state_nxt;
   logic [CW-1:0] cnt;
   logic          accept, done, abort;

   // PREADY only matters in ACCESS, so a stale high from the completer is harmless
   assign accept = cmd_valid && cmd_ready;
   assign done   = (state == ACCESS) && apb.PREADY;
   assign abort  = (state == ACCESS) && !apb.PREADY && (TIMEOUT != 0) && (cnt == LIMIT);

   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) state <= IDLE;
      else state <= state_nxt;

   always_comb
      state_nxt = (state == IDLE)  ? (accept ? SETUP : IDLE) :
                  (state == SETUP) ? ACCESS :
                  (done || abort)  ? IDLE : ACCESS;

   always_comb begin
      cmd_ready   = (state == IDLE);
      apb.PSEL    = (state != IDLE);
      apb.PENABLE = (state == ACCESS);
   end

   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         apb.PWRITE <= 1'b0;
         apb.PADDR  <= '0;
         apb.PWDATA <= '0;
         cnt        <= '0;
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         if (accept) begin
            apb.PWRITE <= cmd_write;
            apb.PADDR  <= cmd_addr;
            apb.PWDATA <= cmd_wdata;
         end
         if (state == SETUP) cnt <= '0;
         else if (state == ACCESS && !apb.PREADY && cnt != CNT_MAX) cnt <= cnt + 1'b1;
         rsp_valid <= done || abort;
         rsp_err   <= abort;
         if (done || abort) rsp_rdata <= (done && !apb.PWRITE) ? apb.PRDATA : '0;
      end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed checks of apb_master against a behavioural 8-entry
// register-file completer with registered PREADY.
module tb_apb_master;
   import apb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [2:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        cmd_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   int          n_chk = 0, n_fail = 0;

   apb_if bus ();

   apb_master #(.TIMEOUT(16)) dut (
      .PCLK(clk), .PRESETn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .apb(bus)
   );

   always #5 clk = ~clk;

   // completer model: 0 = normal, 1 = PREADY stuck low, 2 = PREADY stuck high
   int          mode = 0;
   logic        rdy_reg;
   logic [31:0] mem [8];
   initial for (int i = 0; i < 8; i++) mem[i] = '0;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) rdy_reg <= 1'b0;
      else rdy_reg <= bus.PSEL && bus.PENABLE && !rdy_reg;
   always @(posedge clk)
      if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) mem[bus.PADDR] <= bus.PWDATA;
   assign bus.PREADY = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : rdy_reg;
   assign bus.PRDATA = mem[bus.PADDR];

   int         setups = 0, bad_setup = 0, bad_addr = 0, bad_ready = 0;
   logic       prev_psel = 1'b0;
   logic [2:0] acc_addr = '0;
   always @(negedge clk) begin
      if (bus.PSEL && !bus.PENABLE) setups++;
      if (bus.PSEL && !prev_psel && bus.PENABLE) bad_setup++;
      if (bus.PENABLE && !bus.PSEL) bad_setup++;
      if (bus.PSEL && bus.PADDR != acc_addr) bad_addr++;
      if (cmd_ready && bus.PSEL) bad_ready++;
      if (cmd_valid && cmd_ready) acc_addr = cmd_addr;
      prev_psel = bus.PSEL;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output int lat, output int pen);
      int n = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      if (!cmd_ready) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 0; pen = 0;
      do begin
         @(negedge clk);
         lat++;
         if (bus.PENABLE) pen++;
      end while (!rsp_valid && lat < 100);
      rd = rsp_rdata; e = rsp_err;
   endtask

   logic [31:0] rd;
   logic        e;
   int          lat, pen, acc, s0, rv;

   initial begin
      #12;
      check("rst_bus", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}, '0);
      check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
      check("rst_ready", cmd_ready, 1);
      @(negedge clk); rst_n = 1'b1;

      xfer(1'b1, 3'd5, 32'hDEADBEEF, rd, e, lat, pen);
      check("t1_wr_lat", lat, 4);
      check("t1_wr_rsp", {e, rd}, 0);
      xfer(1'b0, 3'd5, 32'h0, rd, e, lat, pen);
      check("t1_rd_lat", lat, 4);
      check("t1_rd_data", rd, 32'hDEADBEEF);
      check("t1_rd_err", e, 0);

      s0 = setups;
      for (int i = 0; i < 8; i++) xfer(1'b1, 3'(i), i * 32'h11111111, rd, e, lat, pen);
      for (int i = 0; i < 8; i++) begin
         xfer(1'b0, 3'(i), 32'h0, rd, e, lat, pen);
         check($sformatf("t2_rd%0d", i), {e, rd}, {1'b0, i * 32'h11111111});
      end
      check("t2_setups", setups - s0, 16);

      acc = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_write = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cmd_addr = 3'(i);
         @(negedge clk);
         if (cmd_ready) acc++;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("t3_accepts", acc, 10);
      check("t3_setup_shape", bad_setup, 0);
      check("t3_paddr_stable", bad_addr, 0);
      check("t3_ready_busy", bad_ready, 0);

      mode = 1;
      xfer(1'b0, 3'd2, 32'h0, rd, e, lat, pen);
      check("t4_penable_cycles", pen, 16);
      check("t4_lat", lat, 18);
      check("t4_rsp", {e, rd}, {1'b1, 32'h0});
      @(negedge clk);
      check("t4_idle", {cmd_ready, bus.PSEL, rsp_valid}, 3'b100);
      mode = 0;

      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd6; cmd_wdata = 32'h12345678;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      check("t5_in_access", {bus.PSEL, bus.PENABLE}, 2'b11);
      rst_n = 1'b0;
      #1;
      check("t5_bus_drop", {bus.PSEL, bus.PENABLE}, 2'b00);
      rv = 0;
      repeat (3) begin @(negedge clk); if (rsp_valid) rv++; end
      rst_n = 1'b1;
      repeat (3) begin @(negedge clk); if (rsp_valid) rv++; end
      check("t5_no_rsp", rv, 0);
      check("t5_no_write", mem[6], 32'h66666666);
      xfer(1'b1, 3'd3, 32'hA5A5_0303, rd, e, lat, pen);
      check("t5_wr_after", {e, lat[3:0]}, {1'b0, 4'd4});
      xfer(1'b0, 3'd3, 32'h0, rd, e, lat, pen);
      check("t5_rd_after", rd, 32'hA5A5_0303);

      mode = 2;
      rv = 0;
      repeat (3) begin @(negedge clk); if (rsp_valid || bus.PSEL) rv++; end
      check("t6_idle_quiet", rv, 0);
      xfer(1'b0, 3'd4, 32'h0, rd, e, lat, pen);
      check("t6_lat", lat, 3);
      check("t6_penable_cycles", pen, 1);
      check("t6_rd", {e, rd}, {1'b0, 32'h44444444});
      mode = 0;

      check("final_setup_shape", bad_setup, 0);
      check("final_ready_busy", bad_ready, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
